// File: rtl/gf180mcu_osu_sc_9t_clkbuf_divgate.sv
// ---------------------------------------------------------------------------
// gf180mcu_osu_sc_9t_clkbuf_divgate
//
// Multi-channel clock buffer for a clock-tree root. Each of the N channels
// drives its own output clock, which is one of:
//   - CLK passed through, gated glitch-free by a low-transparent latch
//     (bypass, DIV == 0), or
//   - CLK divided by P = DIV+1. The output is high for floor(P/2) cycles
//     and low for the rest (divide, DIV != 0).
// Run requests and divide ratios are taken only at a period boundary, so an
// output never produces a shortened or stretched pulse. When a channel
// switches between bypass and divide it first spends one CLK cycle idle.
// This keeps the output mux from switching while either of its inputs can
// be high.
//
// Parameters:
//   N    number of output clock channels (>= 1)
//   W    width of each per-channel divide field (P = 1 .. 2^W)
//
// Ports:
//   CLK  in   1    source clock
//   RN   in   1    asynchronous active-low reset
//   EN   in   N    per-channel run request, sampled on CLK rising edge
//   DIV  in   N*W  per-channel divide field, channel i uses DIV[i*W +: W]
//   Y    out  N    per-channel output clock
//   ACT  out  N    per-channel status, 1 while the channel is running
// ---------------------------------------------------------------------------
module gf180mcu_osu_sc_9t_clkbuf_divgate #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [N-1:0]     EN,
  input  logic [N*W-1:0]   DIV,
  output logic [N-1:0]     Y,
  output logic [N-1:0]     ACT
);

  logic [W-1:0] cnt_q   [N];
  logic [W-1:0] cnt_d   [N];
  logic [W-1:0] ratio_q [N];
  logic [W-1:0] ratio_d [N];
  logic [N-1:0] run_q, run_d;
  logic [N-1:0] byp_q, byp_d;
  logic [N-1:0] y_q,   y_d;
  logic [N-1:0] g_lat;
  logic [N-1:0] bnd;
  logic [N-1:0] div_zero;

  // Length of the high phase, floor((ratio+1)/2), one bit wider so that
  // ratio = 2^W-1 does not overflow.
  function automatic logic [W:0] half_period(input logic [W-1:0] ratio);
    logic [W:0] p;
    p = {1'b0, ratio} + (W+1)'(1);
    return p >> 1;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_d[i]   = cnt_q[i];
      ratio_d[i] = ratio_q[i];
    end
    run_d    = run_q;
    byp_d    = byp_q;
    y_d      = y_q;
    bnd      = '0;
    div_zero = '0;

    for (int i = 0; i < N; i++) begin
      div_zero[i] = (DIV[i*W +: W] == '0);
      // In bypass every edge closes a period. In divide mode cnt runs
      // 0..ratio, so the last cycle of the period is cnt == ratio.
      bnd[i] = byp_q[i] || (cnt_q[i] == ratio_q[i]);

      if (!run_q[i]) begin
        // Idle: sample the request every edge. A divide start raises y
        // right away, because the first high phase begins at this edge.
        run_d[i]   = EN[i];
        ratio_d[i] = DIV[i*W +: W];
        byp_d[i]   = div_zero[i];
        cnt_d[i]   = '0;
        y_d[i]     = EN[i] && !div_zero[i];
      end else if (bnd[i]) begin
        cnt_d[i] = '0;
        if (!EN[i] || (div_zero[i] != byp_q[i])) begin
          // Stop, or the mode is changing. Drop to idle for one cycle and
          // leave ratio/byp untouched. Idle reloads them on the next edge.
          run_d[i] = 1'b0;
          y_d[i]   = 1'b0;
        end else begin
          ratio_d[i] = DIV[i*W +: W];
          y_d[i]     = !byp_q[i];
        end
      end else begin
        cnt_d[i] = cnt_q[i] + W'(1);
        y_d[i]   = ({1'b0, cnt_d[i]} < half_period(ratio_q[i]));
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i]   <= '0;
        ratio_q[i] <= '0;
      end
      run_q <= '0;
      byp_q <= '1;
      y_q   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i]   <= cnt_d[i];
        ratio_q[i] <= ratio_d[i];
      end
      run_q <= run_d;
      byp_q <= byp_d;
      y_q   <= y_d;
    end
  end

  // Bypass gate. The latch is transparent while CLK is low, so it can only
  // change while the gated output is already low. Each output pulse is
  // therefore a whole CLK high phase. Reset clears it immediately.
  always_latch begin
    if (!RN) begin
      g_lat <= '0;
    end else if (!CLK) begin
      g_lat <= run_q;
    end
  end

  // byp_q changes only at a rising edge. Both mux inputs are low at a
  // mode-switch edge: the gate closed during the idle cycle and y_q is
  // still low. So the mux never switches between a high and a low input.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      Y[i] = byp_q[i] ? (CLK & g_lat[i]) : y_q[i];
    end
  end

  assign ACT = run_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_clkbuf_divgate.sv
module tb_gf180mcu_osu_sc_9t_clkbuf_divgate;
  localparam int N = 4;
  localparam int W = 4;

  logic           CLK = 1'b0;
  logic           RN;
  logic [N-1:0]   EN;
  logic [N*W-1:0] DIV;
  logic [N-1:0]   Y;
  logic [N-1:0]   ACT;

  gf180mcu_osu_sc_9t_clkbuf_divgate #(.N(N), .W(W)) dut (
    .CLK (CLK),
    .RN  (RN),
    .EN  (EN),
    .DIV (DIV),
    .Y   (Y),
    .ACT (ACT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: each channel tracks whether it runs, whether it is a
  // bypass, its period length P and how many cycles into that period it is.
  int m_run  [N];
  int m_byp  [N];
  int m_P    [N];
  int m_pos  [N];
  int m_gate [N];   // run status during the low phase before the last edge

  logic [N-1:0] exp_hi, exp_lo, exp_act;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      m_byp[i]  = 1;
      m_P[i]    = 1;
      m_pos[i]  = 0;
      m_gate[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < N; i++) begin
      int d;
      int e;
      d = int'(DIV[i*W +: W]);
      e = int'(EN[i]);
      m_gate[i] = m_run[i];
      if (m_run[i] == 0) begin
        m_run[i] = e;
        m_byp[i] = (d == 0) ? 1 : 0;
        m_P[i]   = d + 1;
        m_pos[i] = 0;
      end else if (m_byp[i] == 1 || m_pos[i] == m_P[i] - 1) begin
        m_pos[i] = 0;
        if (e == 0 || ((d == 0) ? 1 : 0) != m_byp[i]) m_run[i] = 0;
        else m_P[i] = d + 1;
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
    end
  endfunction

  function automatic void model_expect();
    for (int i = 0; i < N; i++) begin
      logic dv;
      dv = (m_run[i] != 0) && (m_pos[i] < m_P[i] / 2);
      exp_act[i] = (m_run[i] != 0);
      exp_hi[i]  = (m_byp[i] != 0) ? (m_gate[i] != 0) : dv;
      exp_lo[i]  = (m_byp[i] != 0) ? 1'b0 : dv;
    end
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One CLK cycle: check Y and ACT mid-high, then check Y mid-low.
  // Inputs are only changed by the caller, after this returns.
  task automatic tick(input string tag);
    @(posedge CLK);
    if (RN) model_edge();
    model_expect();
    #1;
    chk({tag, "_yhi"}, Y, exp_hi);
    chk({tag, "_act"}, ACT, exp_act);
    @(negedge CLK);
    #1;
    chk({tag, "_ylo"}, Y, exp_lo);
  endtask

  initial begin
    RN  = 1'b0;
    EN  = '0;
    DIV = '0;
    model_reset();
    repeat (2) tick("reset");
    RN = 1'b1;
    repeat (10) tick("idle");

    // Ch0 P=4, ch1 P=5
    DIV[0*W +: W] = 4'd3;
    DIV[1*W +: W] = 4'd4;
    EN = 4'b0011;
    repeat (20) tick("div45");

    // Ratio change mid-period, ch0 P=4 -> P=8
    tick("pre_chg");
    DIV[0*W +: W] = 4'd7;
    repeat (24) tick("ratio_chg");

    // Divide -> bypass, then back
    DIV[0*W +: W] = 4'd0;
    repeat (12) tick("to_byp");
    DIV[0*W +: W] = 4'd3;
    repeat (12) tick("to_div");

    // Bypass start from idle, then EN drop
    EN[0] = 1'b0;
    repeat (4) tick("stop0");
    DIV[0*W +: W] = 4'd0;
    EN[0] = 1'b1;
    repeat (6) tick("byp_run");
    EN[0] = 1'b0;
    repeat (4) tick("byp_stop");

    // All channels with different periods, toggling ch2
    DIV = {4'd2, 4'd1, 4'd0, 4'd15};
    EN  = 4'b1111;
    repeat (34) tick("multi");
    EN[2] = 1'b0;
    repeat (7) tick("multi_ch2off");
    EN[2] = 1'b1;
    repeat (9) tick("multi_ch2on");

    // Random EN/DIV activity
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int ch;
        ch = $urandom_range(0, N - 1);
        if ($urandom_range(0, 1) == 1) EN[ch] = ~EN[ch];
        else if ($urandom_range(0, 3) == 0) DIV[ch*W +: W] = '0;
        else DIV[ch*W +: W] = W'($urandom_range(0, 15));
      end
      tick("rnd");
    end

    // Asynchronous reset in the middle of a high phase
    DIV = {4'd2, 4'd1, 4'd0, 4'd3};
    EN  = 4'b1111;
    repeat (6) tick("pre_rst");
    @(posedge CLK);
    model_edge();
    #2;
    RN = 1'b0;
    model_reset();
    model_expect();
    #1;
    chk("async_rst_y", Y, exp_hi);
    chk("async_rst_act", ACT, exp_act);
    EN = '0;
    @(negedge CLK);
    #1;
    chk("async_rst_ylo", Y, exp_lo);
    repeat (2) tick("rst_hold");
    RN = 1'b1;
    repeat (6) tick("post_rst");
    EN = 4'b1111;
    repeat (10) tick("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
